// File: rtl/disp_pkg.sv
`default_nettype none
// =====================================================================
// disp_pkg : opcodes, FSM encodings and defaults for the display
//            command scheduler.   Revision: 1.0
// =====================================================================
package disp_pkg;

  localparam int ADDR_W_DEF = 13;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_SET_ADDR = 8'h01;
  localparam logic [7:0] OP_WRITE    = 8'h02;
  localparam logic [7:0] OP_FILL     = 8'h03;
  localparam logic [7:0] OP_SET_ATTR = 8'h04;

  typedef enum logic [2:0] {
    P_OPCODE = 3'd0,
    P_ARG1   = 3'd1,
    P_ARG2   = 3'd2,
    P_WRITE  = 3'd3,
    P_FILL   = 3'd4
  } pstate_e;

  typedef enum logic [2:0] {
    R_IDLE    = 3'd0,
    R_ASSERT  = 3'd1,
    R_WAIT    = 3'd2,
    R_LATCH   = 3'd3,
    R_RELEASE = 3'd4
  } rstate_e;

  // Defined opcodes are contiguous from 0x00 to 0x04.
  function automatic logic op_known(input logic [7:0] op);
    return (op <= OP_SET_ATTR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_cmd_sched_if.sv
`default_nettype none
// =====================================================================
// disp_cmd_sched_if : command FIFO, timing and VRAM write bundle.
//                     Revision: 1.0
// =====================================================================
interface disp_cmd_sched_if
  import disp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [1:0]        tick;
  logic              nef;
  logic [7:0]        disp_cmd_in;
  logic              disp_cmd_rd;
  logic              vram_busy;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic [7:0]        attr;
  logic              cmd_err;

  modport master (
    output tick, nef, disp_cmd_in, vram_busy,
    input  disp_cmd_rd, vram_we, vram_addr, vram_wdata, attr, cmd_err
  );

  modport slave (
    input  tick, nef, disp_cmd_in, vram_busy,
    output disp_cmd_rd, vram_we, vram_addr, vram_wdata, attr, cmd_err
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_seq.sv
`default_nettype none
// =====================================================================
// fifo_rd_seq : tick-aligned FIFO read strobe, one byte per read.
//               Revision: 1.0
// =====================================================================
module fifo_rd_seq
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] tick_i,
  input  logic       nef_i,
  input  logic       go_i,
  input  logic [7:0] cmd_i,
  output logic       rd_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o
);
  rstate_e state_q, state_d;
  logic    rd_q, rd_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= R_IDLE;
      rd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
    end
  end

  // Strobe falls at tick 0, data is taken at tick 2 of the next period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:    if (tick_i == 2'd0 && nef_i && go_i) state_d = R_ASSERT;
      R_ASSERT:  if (tick_i == 2'd3) state_d = R_WAIT;
      R_WAIT:    if (tick_i == 2'd1) state_d = R_LATCH;
      R_LATCH:   state_d = R_RELEASE;
      R_RELEASE: state_d = R_IDLE;
      default:   state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_d = (state_d == R_IDLE);
  end

  assign rd_o         = rd_q;
  assign byte_valid_o = (state_q == R_LATCH);
  assign byte_o       = cmd_i;

endmodule
`default_nettype wire

// File: rtl/disp_cmd_sched.sv
`default_nettype none
// =====================================================================
// disp_cmd_sched : display command parser and VRAM write scheduler.
//                  Revision: 1.0
// =====================================================================
module disp_cmd_sched
  import disp_pkg::*;
#(
  parameter int         ADDR_W   = ADDR_W_DEF,
  parameter logic [7:0] ATTR_RST = 8'h0F
) (
  input  logic            clk,
  input  logic            nrst,
  disp_cmd_sched_if.slave bus
);
  pstate_e           p_q, p_d;
  logic [7:0]        op_q, op_d, arg1_q, arg1_d, attr_q, attr_d, wdata_q, wdata_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic              err_q, err_d, we_q, we_d;
  logic              w_go, w_grant, w_valid, w_rd;
  logic [7:0]        w_byte;

  assign w_go    = !(p_q inside {P_WRITE, P_FILL});
  // A write is issued only on an edge that sees scan-out away from VRAM.
  assign w_grant = !w_go && !bus.vram_busy;

  fifo_rd_seq u_rd_seq (
    .clk          (clk),
    .nrst         (nrst),
    .tick_i       (bus.tick),
    .nef_i        (bus.nef),
    .go_i         (w_go),
    .cmd_i        (bus.disp_cmd_in),
    .rd_o         (w_rd),
    .byte_valid_o (w_valid),
    .byte_o       (w_byte)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p_q     <= P_OPCODE;
      op_q    <= 8'h00;
      arg1_q  <= 8'h00;
      attr_q  <= ATTR_RST;
      wdata_q <= 8'h00;
      cnt_q   <= 9'd0;
      ptr_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      p_q     <= p_d;
      op_q    <= op_d;
      arg1_q  <= arg1_d;
      attr_q  <= attr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    p_d = p_q;
    case (p_q)
      P_OPCODE: if (w_valid && op_known(w_byte) && w_byte != OP_NOP) p_d = P_ARG1;
      P_ARG1: begin
        if (w_valid) begin
          case (op_q)
            OP_WRITE:    p_d = P_WRITE;
            OP_SET_ATTR: p_d = P_OPCODE;
            default:     p_d = P_ARG2;
          endcase
        end
      end
      P_ARG2:  if (w_valid) p_d = (op_q == OP_FILL) ? P_FILL : P_OPCODE;
      P_WRITE: if (w_grant) p_d = P_OPCODE;
      P_FILL:  if (w_grant && cnt_q == 9'd1) p_d = P_OPCODE;
      default: p_d = P_OPCODE;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    arg1_d  = arg1_q;
    attr_d  = attr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    err_d   = err_q;
    we_d    = 1'b0;
    case (p_q)
      P_OPCODE: begin
        if (w_valid) begin
          op_d = w_byte;
          if (!op_known(w_byte)) err_d = 1'b1;
        end
      end
      P_ARG1: begin
        if (w_valid) begin
          arg1_d = w_byte;
          if (op_q == OP_SET_ATTR) attr_d = w_byte;
        end
      end
      P_ARG2: begin
        if (w_valid) begin
          if (op_q == OP_FILL) cnt_d = (w_byte == 8'd0) ? 9'd256 : {1'b0, w_byte};
          else                 ptr_d = ADDR_W'({w_byte, arg1_q});
        end
      end
      P_WRITE, P_FILL: begin
        // Address and data track the pointer so they hold steady while stalled.
        addr_d  = ptr_q;
        wdata_d = arg1_q;
        if (w_grant) begin
          we_d  = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q - 9'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.disp_cmd_rd = w_rd;
  assign bus.vram_we     = we_q;
  assign bus.vram_addr   = addr_q;
  assign bus.vram_wdata  = wdata_q;
  assign bus.attr        = attr_q;
  assign bus.cmd_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_cmd_sched.sv
`default_nettype none
// tb_disp_cmd_sched : directed command streams checked against a command-level
// model of VRAM writes, attribute/error state and FIFO strobe timing.
module tb_disp_cmd_sched;

  logic clk;
  logic nrst;

  disp_cmd_sched_if #(.ADDR_W(13)) bus();

  disp_cmd_sched #(.ADDR_W(13), .ATTR_RST(8'h0F)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- command-level model ----------------
  logic [7:0]  fifo_q[$];
  logic [20:0] exp_wr[$];
  int          m_st;
  logic [7:0]  m_op, m_a1, m_attr;
  logic        m_err;
  logic [12:0] m_ptr;

  task automatic reset_model();
    m_st   = 0;
    m_op   = 8'h00;
    m_a1   = 8'h00;
    m_attr = 8'h0F;
    m_err  = 1'b0;
    m_ptr  = 13'd0;
    exp_wr.delete();
    fifo_q.delete();
  endtask

  task automatic feed(input logic [7:0] b);
    int n;
    fifo_q.push_back(b);
    case (m_st)
      0: begin
        m_op = b;
        if (b >= 8'h01 && b <= 8'h04) m_st = 1;
        else if (b != 8'h00)          m_err = 1'b1;
      end
      1: begin
        m_a1 = b;
        if (m_op == 8'h02) begin
          exp_wr.push_back({m_ptr, b});
          m_ptr = m_ptr + 13'd1;
          m_st  = 0;
        end else if (m_op == 8'h04) begin
          m_attr = b;
          m_st   = 0;
        end else begin
          m_st = 2;
        end
      end
      default: begin
        if (m_op == 8'h01) begin
          m_ptr = 13'({b, m_a1});
        end else begin
          n = (b == 8'h00) ? 256 : int'(b);
          for (int i = 0; i < n; i++) begin
            exp_wr.push_back({m_ptr, m_a1});
            m_ptr = m_ptr + 13'd1;
          end
        end
        m_st = 0;
      end
    endcase
  endtask

  task automatic send(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) feed(v[63-8*i -: 8]);
  endtask

  // ---------------- FIFO / timing / VRAM-busy driver ----------------
  logic       busy_mode = 1'b0;
  logic [4:0] busy_pat  = 5'b01011;   // 1,1,0,1,0 repeating

  initial begin
    int   since = 0;
    int   bidx  = 0;
    logic prev  = 1'b1;
    bus.tick        = 2'd0;
    bus.nef         = 1'b0;
    bus.disp_cmd_in = 8'hEE;
    bus.vram_busy   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tick = bus.tick + 2'd1;
      if (!nrst) begin
        since = 0;
      end else if (!bus.disp_cmd_rd) begin
        since++;
      end else begin
        if (!prev && fifo_q.size() > 0) fifo_q.delete(0);
        since = 0;
      end
      prev = bus.disp_cmd_rd;
      // Valid data only in the cycle leading to the expected capture edge.
      bus.disp_cmd_in = (since == 6 && fifo_q.size() > 0) ? fifo_q[0] : 8'hEE;
      bus.nef         = (fifo_q.size() > 0);
      bus.vram_busy   = busy_mode ? busy_pat[bidx] : 1'b0;
      bidx            = (bidx + 1) % 5;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [1:0]  tick_e;
  logic        nef_e, busy_e;
  int          cyc = 0;
  int          wr_cnt = 0, fall_cnt = 0, fall_cyc = 0;
  logic        fall_valid = 1'b0;
  logic [12:0] last_a = 13'd0;
  logic [7:0]  last_d = 8'd0;

  initial begin
    forever begin
      @(posedge clk);
      tick_e = bus.tick;
      nef_e  = bus.nef;
      busy_e = bus.vram_busy;
      cyc++;
    end
  end

  initial begin
    logic prev_rd = 1'b1;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        chk("rst_rd",    int'(bus.disp_cmd_rd), 1);
        chk("rst_we",    int'(bus.vram_we), 0);
        chk("rst_addr",  int'(bus.vram_addr), 0);
        chk("rst_wdata", int'(bus.vram_wdata), 0);
        chk("rst_attr",  int'(bus.attr), 'h0F);
        chk("rst_err",   int'(bus.cmd_err), 0);
        prev_rd    = 1'b1;
        fall_valid = 1'b0;
      end else begin
        if (bus.vram_we) begin
          wr_cnt++;
          last_a = bus.vram_addr;
          last_d = bus.vram_wdata;
          chk("we_busy_free", int'(busy_e), 0);
          chk("write_expected", int'(exp_wr.size() != 0), 1);
          if (exp_wr.size() != 0) begin
            chk("wr_addr", int'(bus.vram_addr), int'(exp_wr[0][20:8]));
            chk("wr_data", int'(bus.vram_wdata), int'(exp_wr[0][7:0]));
            exp_wr.delete(0);
          end
        end
        if (prev_rd && !bus.disp_cmd_rd) begin
          fall_cnt++;
          chk("fall_tick", int'(tick_e), 0);
          chk("fall_nef", int'(nef_e), 1);
          if (fall_valid) chk("fall_spacing", int'((cyc - fall_cyc) >= 8), 1);
          fall_cyc   = cyc;
          fall_valid = 1'b1;
        end
        if (!prev_rd && bus.disp_cmd_rd) chk("rise_offset", cyc - fall_cyc, 7);
        prev_rd = bus.disp_cmd_rd;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_quiet(input int budget);
    int idle = 0;
    int n    = 0;
    while (idle < 12 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (fifo_q.size() == 0 && bus.disp_cmd_rd && exp_wr.size() == 0) idle++;
      else idle = 0;
    end
    chk("quiet_in_budget", int'(idle >= 12), 1);
  endtask

  task automatic check_regs();
    chk("attr_model", int'(bus.attr), int'(m_attr));
    chk("err_model",  int'(bus.cmd_err), int'(m_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base_w, base_f, n;
    nrst = 1'b0;
    reset_model();
    repeat (4) @(negedge clk);
    #1;
    chk("init_rd",   int'(bus.disp_cmd_rd), 1);
    chk("init_attr", int'(bus.attr), 'h0F);
    nrst = 1'b1;

    // Empty FIFO: no strobe at all.
    base_f = fall_cnt;
    repeat (20) @(negedge clk);
    #1;
    chk("idle_no_strobe", fall_cnt - base_f, 0);

    // SET_ADDR 0x1234 then WRITE 0xAB.
    base_w = wr_cnt; base_f = fall_cnt;
    send(5, 64'h01_34_12_02_AB_00_00_00);
    wait_quiet(400);
    chk("t1_writes", wr_cnt - base_w, 1);
    chk("t1_addr",   int'(last_a), 'h1234);
    chk("t1_data",   int'(last_d), 'hAB);
    chk("t1_reads",  fall_cnt - base_f, 5);
    check_regs();

    // Pointer at 0x1FFF, FILL 0x55 with count 0 -> 256 writes across the wrap.
    base_w = wr_cnt;
    send(6, 64'h01_FF_1F_03_55_00_00_00);
    wait_quiet(1200);
    chk("t2_writes", wr_cnt - base_w, 256);
    chk("t2_last_addr", int'(last_a), 'h00FE);
    chk("t2_last_data", int'(last_d), 'h55);

    // FILL 4 with scan-out contention.
    base_w    = wr_cnt;
    busy_mode = 1'b1;
    send(3, 64'h03_66_04_00_00_00_00_00);
    wait_quiet(600);
    busy_mode = 1'b0;
    chk("t3_writes", wr_cnt - base_w, 4);
    chk("t3_last_addr", int'(last_a), 'h0102);
    chk("t3_last_data", int'(last_d), 'h66);

    // Undefined opcode, then SET_ATTR 0x3C.
    base_w = wr_cnt;
    send(3, 64'h07_04_3C_00_00_00_00_00);
    wait_quiet(400);
    chk("t4_err",    int'(bus.cmd_err), 1);
    chk("t4_attr",   int'(bus.attr), 'h3C);
    chk("t4_writes", wr_cnt - base_w, 0);
    check_regs();

    // NOP leaves the sticky error set.
    send(1, 64'h00_00_00_00_00_00_00_00);
    wait_quiet(200);
    chk("t5_err_sticky", int'(bus.cmd_err), 1);
    check_regs();

    // Reset during a FILL of 10 after three writes.
    base_w = wr_cnt;
    send(6, 64'h01_00_01_03_99_0A_00_00);
    n = 0;
    while ((wr_cnt - base_w) < 3 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t6_three_writes", wr_cnt - base_w, 3);
    nrst = 1'b0;
    #1;
    chk("t6_rst_we",    int'(bus.vram_we), 0);
    chk("t6_rst_rd",    int'(bus.disp_cmd_rd), 1);
    chk("t6_rst_addr",  int'(bus.vram_addr), 0);
    chk("t6_rst_wdata", int'(bus.vram_wdata), 0);
    chk("t6_rst_attr",  int'(bus.attr), 'h0F);
    chk("t6_rst_err",   int'(bus.cmd_err), 0);
    reset_model();
    repeat (3) @(negedge clk);
    #1;
    nrst   = 1'b1;
    base_w = wr_cnt; base_f = fall_cnt;
    repeat (40) @(negedge clk);
    #1;
    chk("t6_no_write_after", wr_cnt - base_w, 0);
    chk("t6_no_read_after",  fall_cnt - base_f, 0);

    // Pointer restarts at zero after reset.
    base_w = wr_cnt;
    send(2, 64'h02_77_00_00_00_00_00_00);
    wait_quiet(300);
    chk("t7_writes", wr_cnt - base_w, 1);
    chk("t7_addr",   int'(last_a), 'h0000);
    chk("t7_data",   int'(last_d), 'h77);
    check_regs();

    // FIFO runs dry after an opcode; parser resumes when bytes arrive.
    base_w = wr_cnt;
    send(1, 64'h01_00_00_00_00_00_00_00);
    wait_quiet(200);
    repeat (30) @(negedge clk);
    #1;
    send(4, 64'h10_00_02_5A_00_00_00_00);
    wait_quiet(400);
    chk("t8_writes", wr_cnt - base_w, 1);
    chk("t8_addr",   int'(last_a), 'h0010);
    chk("t8_data",   int'(last_d), 'h5A);
    check_regs();

    chk("exp_drained", exp_wr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
